// File: rtl/vga_bitmap_display.sv
// VGA bitmap display: pixel-divided timing generator, dual-port framebuffer,
// programmable palette and a two-stage scan pipeline.
module vga_bitmap_display #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int PIX_DIV     = 2,
  parameter int SCALE_SHIFT = 2,
  parameter int BPP         = 1,
  parameter int WORD        = 16,
  parameter int ADDR_W      = 11,
  parameter int COLOR_W     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WORD-1:0]        wr_data,
  input  logic                   pal_we,
  input  logic [BPP-1:0]         pal_idx,
  input  logic [3*COLOR_W-1:0]   pal_data,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   vblank,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(PIX_DIV);
  localparam int P       = WORD / BPP;
  localparam int PSH     = $clog2(P);
  localparam int L       = (H_VISIBLE >> SCALE_SHIFT) / P;
  localparam int CW      = 3 * COLOR_W;
  localparam int NPAL    = 2 ** BPP;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DW-1:0]     div_q, div_d;
  logic              pix_en;
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic              vblank_q, vblank_d;
  logic              frame_start_q, frame_start_d;

  logic [WORD-1:0]   mem [2**ADDR_W];
  logic [WORD-1:0]   word_q;
  logic [31:0]       addr_full;
  logic [ADDR_W-1:0] rd_addr;
  logic              addr_unused;

  logic [PSH-1:0]    k1_q, k1_d;
  logic              vis1_q, vis1_d;
  logic              hs1_q, hs1_d;
  logic              vs1_q, vs1_d;
  logic [BPP-1:0]    field;

  logic [CW-1:0]     pal_q [NPAL];
  logic [CW-1:0]     pal_d [NPAL];
  logic [CW-1:0]     rgb_q, rgb_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;

  assign pix_en = (div_q == DIV_LAST);

  // vblank is registered from the next-state line count so it tracks v_q exactly.
  always_comb begin
    div_d         = div_q + DW'(1);
    h_d           = h_q;
    v_d           = v_q;
    vblank_d      = vblank_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      div_d         = '0;
      frame_start_d = (h_q == H_LAST) && (v_q == V_LAST);
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
      vblank_d = (v_d >= V_VIS);
    end
  end

  assign addr_full   = 32'(v_q[VW-1:SCALE_SHIFT]) * 32'(L)
                     + 32'(h_q[HW-1:SCALE_SHIFT+PSH]);
  assign rd_addr     = addr_full[ADDR_W-1:0];
  assign addr_unused = ^addr_full[31:ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Stage 1: framebuffer word plus the side-band that must stay aligned with it.
  always_ff @(posedge clk) begin
    if (rst) word_q <= '0;
    else if (pix_en) word_q <= mem[rd_addr];
  end

  always_comb begin
    k1_d   = k1_q;
    vis1_d = vis1_q;
    hs1_d  = hs1_q;
    vs1_d  = vs1_q;
    if (pix_en) begin
      k1_d   = h_q[SCALE_SHIFT+PSH-1:SCALE_SHIFT];
      vis1_d = (h_q < H_VIS) && (v_q < V_VIS);
      hs1_d  = (h_q >= HS_START && h_q <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vs1_d  = (v_q >= VS_START && v_q <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  always_comb begin
    field = '0;
    for (int i = 0; i < P; i++) begin
      if (k1_q == PSH'(i)) field = word_q[WORD-1-i*BPP -: BPP];
    end
  end

  // Stage 2 reads the palette before any same-clk write lands.
  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_en) begin
      rgb_d   = vis1_q ? pal_q[field] : '0;
      hsync_d = hs1_q;
      vsync_d = vs1_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NPAL; i++) begin
      pal_d[i] = pal_q[i];
      if (pal_we && pal_idx == BPP'(i)) pal_d[i] = pal_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
      k1_q          <= '0;
      vis1_q        <= 1'b0;
      hs1_q         <= ~HSYNC_POL;
      vs1_q         <= ~VSYNC_POL;
      rgb_q         <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      for (int i = 0; i < NPAL; i++) begin
        if (i == 0) pal_q[i] <= '0;
        else        pal_q[i] <= '1;
      end
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
      k1_q          <= k1_d;
      vis1_q        <= vis1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      for (int i = 0; i < NPAL; i++) pal_q[i] <= pal_d[i];
    end
  end

  assign vga_r       = rgb_q[CW-1 -: COLOR_W];
  assign vga_g       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_b       = rgb_q[COLOR_W-1:0];
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_bitmap_display.md
# vga_bitmap_display

Parametrised single-clock VGA bitmap display: timing generator, internal dual-port framebuffer, and programmable palette in one block. The CPU writes through a word port and the block scans out continuously. Sync timing, pixel divider, scaling, bits-per-pixel and colour depth are all parametrised, and the block adds a palette, frame-start and vblank status, and sync polarity control. It sits on the peripheral bus beside the CPU and drives the board VGA pins directly.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_VISIBLE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- HSYNC_POL / VSYNC_POL, 0 / 0, active level of each sync output
- PIX_DIV, 2, clk cycles per pixel; must be ≥2
- SCALE_SHIFT, 2, each framebuffer pixel covers 2^S × 2^S screen pixels
- BPP, 1, bits per pixel; one of 1, 2, 4
- WORD, 16, framebuffer word width
- ADDR_W, 11, framebuffer address width (depth 2^ADDR_W)
- COLOR_W, 1, bits per colour channel
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  framebuffer write strobe
- wr_addr  in  ADDR_W  framebuffer word address
- wr_data  in  WORD  framebuffer write data
- pal_we  in  1  palette write strobe
- pal_idx  in  BPP  palette entry to write
- pal_data  in  3*COLOR_W  palette entry, packed {r,g,b}
- vga_hsync / vga_vsync  out  1  sync outputs
- vga_r / vga_g / vga_b  out  COLOR_W  colour outputs
- vblank  out  1  high while the line counter is ≥ V_VISIBLE
- frame_start  out  1  one-clk pulse at the start of each frame

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP. V_TOTAL is the vertical equivalent (800/525 at defaults).
- Divider counts 0..PIX_DIV-1. pix_en is high when it equals PIX_DIV-1.
- On pix_en, h increments. It wraps from H_TOTAL-1 to 0 and increments v. v wraps from V_TOTAL-1 to 0.
- Sync windows:
  - hsync is active for h in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1].
  - vsync is active for v in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1].
- Visible region: h<H_VISIBLE and v<V_VISIBLE. Outside it, rgb is forced to 0.
- Address calculation:
  - Logical x = h>>S, y = v>>S.
  - P = WORD/BPP pixels per word. L = (H_VISIBLE>>S)/P words per line; H_VISIBLE>>S must be divisible by P.
  - Word address = y*L + x/P. Pixel k = x mod P occupies bits [WORD-1-k*BPP -: BPP], MSB-first.
- Framebuffer is 2^ADDR_W words. The write port is independent of scan-out.
- A write in clk n is visible to a scan read in clk n+1 or later. For a same-clk read of the same address, old or new data is acceptable.
- Palette:
  - 2^BPP registers, written on pal_we.
  - Reset contents: entry 0 = all zeros; every other entry = all ones (black/white at BPP=1).
- vblank follows the undelayed v counter.
- frame_start pulses for one clk on the pix_en where h = H_TOTAL-1 and v = V_TOTAL-1.

## Timing
- Scan pipeline is fixed at two pixel periods:
  - Period n+1 registers the RAM word and selects the pixel field.
  - Period n+2 registers the palette lookup and blank mask.
- hsync, vsync and rgb are delayed through the same two stages, so they remain mutually aligned. Output for counter position (h,v) appears two pixel periods after the counter reached it.
- All outputs are registered and change only on the clk following pix_en. The exception is frame_start, which is registered on the pix_en clk itself.
- Reset values, held while rst=1 and valid in the clk after rst is sampled:
  - Divider, h, v and pipeline = 0.
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL.
  - rgb = 0, vblank = 0, frame_start = 0.
  - Palette returns to its reset contents.
  - Framebuffer contents are not cleared.
- First pix_en occurs PIX_DIV-1 clks after rst deasserts.
- Reset mid-frame is legal: everything except the framebuffer restarts exactly as from power-on.
- A palette write takes effect on the next stage-2 lookup. A pixel already in stage 2 is not affected.
- Simultaneous pal_we and a scan lookup of the same entry: the lookup uses the old value.

## Test plan
- Defaults, release reset → hsync period 1600 clk, low for 192 clk. vsync period 840000 clk, low for 2 lines. frame_start exactly once per 840000 clk.
- vblank rises at line 480 and falls at line 0. rgb = 0 at every h ≥ 640 or v ≥ 480, including when the framebuffer is all-ones.
- Write word 0 = 0x8000, rest 0 → white at screen x 0..3, y 0..3 only. The first white pixel appears 2 pixel periods after h=0, v=0, aligned with the delayed hsync.
- Write word 1199 = 0x0001 → white only at x 636..639, y 476..479, confirming line stride L=10.
- pal_we with idx 1, data 3'b100, then fill with 0xFFFF → visible area red, r=1, g=b=0.
- Assert rst for 1 clk mid-line → next clk all outputs at reset values and counters at 0. Framebuffer pattern reappears unchanged in the next frame.
